inv_mixcol_sequencer: RTL

Sequences one shared 32-bit InvMixColumns column unit across the four columns of a 128-bit AES decryption state. Each round's state is taken in with a valid/ready handshake and issued to the column unit one column per cycle. Results are collected and the full transformed state is returned with a valid/ready handshake. A bypass mode supports the final decryption round, which has no InvMixColumns. The block sits between the InvShiftRows/InvSubBytes/AddRoundKey path and the round register of the AES-256 decryption core.

---
 rtl/inv_mixcol_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/inv_mixcol_sequencer.sv
// inv_mixcol_sequencer: runs one shared 32-bit InvMixColumns column unit
// over the four columns of a 128-bit AES decryption state.
//
// Ports:
//   clk, rst              rising-edge clock, async active-high reset
//   in_valid/in_ready     input handshake for in_state/in_bypass
//   in_state              state in; column 0 = [127:96], column 3 = [31:0]
//   in_bypass             1 = pass state unchanged (final round)
//   mc_col_out/mc_issue   column issued to the external column unit
//   mc_col_in             column unit result, MC_LAT cycles after issue
//   out_valid/out_ready   output handshake for out_state
//   out_state             transformed state, same column order as in_state
//   busy                  high while a state is being worked on or held
module inv_mixcol_sequencer #(
    parameter int MC_LAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic [31:0]  mc_col_out,
    input  logic [31:0]  mc_col_in,
    output logic         mc_issue,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nx;

    logic [127:0] src;
    logic [127:0] res;
    logic [127:0] res_nx;
    // bit 2 marks "all four columns issued"; issue stops there
    logic [2:0]   issue_idx;
    logic [1:0]   cap_cnt;
    logic         cap_vld;
    logic [1:0]   cap_idx;
    logic         accept;
    logic         last_cap;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_ready && in_valid;
    assign mc_issue  = (state == RUN) && !issue_idx[2];
    assign last_cap  = (state == RUN) && cap_vld && (cap_cnt == 2'd3);

    // Column mux toward the column unit; forced to zero when idle
    always_comb begin
        mc_col_out = 32'h0;
        if (mc_issue) begin
            unique case (issue_idx[1:0])
                2'd0: mc_col_out = src[127:96];
                2'd1: mc_col_out = src[95:64];
                2'd2: mc_col_out = src[63:32];
                2'd3: mc_col_out = src[31:0];
                default: mc_col_out = 32'h0;
            endcase
        end
    end

    // Capture timing follows the column unit latency: the issue flag and
    // column index ride a shift pipe as deep as the unit itself.
    generate
        if (MC_LAT == 0) begin : g_comb
            assign cap_vld = mc_issue;
            assign cap_idx = issue_idx[1:0];
        end else begin : g_pipe
            logic [MC_LAT-1:0] vld_pipe;
            logic [1:0]        idx_pipe [MC_LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_pipe <= '0;
                    for (int i = 0; i < MC_LAT; i++) begin
                        idx_pipe[i] <= 2'd0;
                    end
                end else begin
                    vld_pipe[0] <= mc_issue;
                    idx_pipe[0] <= issue_idx[1:0];
                    for (int i = 1; i < MC_LAT; i++) begin
                        vld_pipe[i] <= vld_pipe[i-1];
                        idx_pipe[i] <= idx_pipe[i-1];
                    end
                end
            end

            assign cap_vld = vld_pipe[MC_LAT-1];
            assign cap_idx = idx_pipe[MC_LAT-1];
        end
    endgenerate

    // Result register with the returning column merged in
    always_comb begin
        res_nx = res;
        if (cap_vld) begin
            unique case (cap_idx)
                2'd0: res_nx[127:96] = mc_col_in;
                2'd1: res_nx[95:64]  = mc_col_in;
                2'd2: res_nx[63:32]  = mc_col_in;
                2'd3: res_nx[31:0]   = mc_col_in;
                default: res_nx = res;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = in_bypass ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_cap) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // out_state is a separate register so it only moves on entry to DONE,
    // never while columns are still landing in res.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src       <= '0;
            res       <= '0;
            out_state <= '0;
            issue_idx <= 3'd0;
            cap_cnt   <= 2'd0;
        end else begin
            if (accept) begin
                src       <= in_state;
                issue_idx <= 3'd0;
                cap_cnt   <= 2'd0;
                if (in_bypass) begin
                    res       <= in_state;
                    out_state <= in_state;
                end else begin
                    res <= '0;
                end
            end
            if (state == RUN) begin
                if (mc_issue) begin
                    issue_idx <= issue_idx + 3'd1;
                end
                if (cap_vld) begin
                    res <= res_nx;
                    if (cap_cnt != 2'd3) begin
                        cap_cnt <= cap_cnt + 2'd1;
                    end
                end
                if (last_cap) begin
                    out_state <= res_nx;
                end
            end
        end
    end

endmodule
